// File: rtl/mant_div_24bit_pkg.sv
// Shared constants and state encoding for the sequential 24-bit mantissa divider.
package mant_div_24bit_pkg;

  localparam int WIDTH = 24;
  localparam int QW    = WIDTH + 2;

  localparam logic [QW-1:0] Q_SAT = {QW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mant_div_24bit_div_step.sv
// One combinational restoring-division step: optional left shift, trial subtract, restore.
module mant_div_24bit_div_step #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] b,
  input  logic             shift_en,
  output logic [WIDTH:0]   r_next,
  output logic             qbit
);

  logic [WIDTH:0] r_sh_s;
  logic [WIDTH:0] b_ext_s;

  // r < b holds between steps, so 2r always fits in WIDTH+1 bits.
  assign r_sh_s  = shift_en ? {r[WIDTH-1:0], 1'b0} : r;
  assign b_ext_s = {1'b0, b};
  assign qbit    = (r_sh_s >= b_ext_s);
  assign r_next  = qbit ? (r_sh_s - b_ext_s) : r_sh_s;

endmodule

// File: rtl/mant_div_24bit.sv
// Sequential unsigned mantissa divider: q = floor(a * 2^25 / b), one quotient bit per clock.
module mant_div_24bit
  import mant_div_24bit_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH+1:0]  q,
  output logic [WIDTH-1:0]  rem,
  output logic              sticky,
  output logic              dz,
  output logic              ovf,
  output logic              busy
);

  localparam int QW    = WIDTH + 2;
  localparam int CNT_W = $clog2(QW);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(QW - 1);

  state_t           state_r;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] b_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH:0]   r_next_s;
  logic             qbit_s;
  logic             shift_en_s;

  // The first CALC step compares a against b directly; every later step doubles r first.
  assign shift_en_s = (cnt_r != CNT_INIT);

  mant_div_24bit_div_step #(.WIDTH(WIDTH)) u_step (
    .r        (r_r),
    .b        (b_r),
    .shift_en (shift_en_s),
    .r_next   (r_next_s),
    .qbit     (qbit_s)
  );

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      q         <= {QW{1'b0}};
      rem       <= {WIDTH{1'b0}};
      sticky    <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      r_r       <= {(WIDTH+1){1'b0}};
      b_r       <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            b_r      <= b;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            dz       <= 1'b0;
            ovf      <= 1'b0;
            rem      <= {WIDTH{1'b0}};
            sticky   <= 1'b0;
            if (b == {WIDTH{1'b0}}) begin
              dz      <= 1'b1;
              q       <= {QW{1'b1}};
              state_r <= DONE;
            end else if ({1'b0, a} >= {b, 1'b0}) begin
              ovf     <= 1'b1;
              q       <= {QW{1'b1}};
              state_r <= DONE;
            end else begin
              q       <= {QW{1'b0}};
              r_r     <= {1'b0, a};
              cnt_r   <= CNT_INIT;
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          r_r   <= r_next_s;
          q     <= {q[QW-2:0], qbit_s};
          cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == {CNT_W{1'b0}}) begin
            rem       <= r_next_s[WIDTH-1:0];
            sticky    <= |r_next_s[WIDTH-1:0];
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          // Early-exit (dz/ovf) results arrive here with out_valid still low; raise it one cycle later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mant_div_24bit.sv
// Self-checking bench for mant_div_24bit: directed table, handshake corner cases, random normalized operands.
module tb_mant_div_24bit;
  import mant_div_24bit_pkg::*;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [25:0] q;
    logic [23:0] rem;
    logic        sticky;
    logic        dz;
    logic        ovf;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] a = 24'd0;
  logic [23:0] b = 24'd0;
  logic        in_ready, out_valid, sticky, dz, ovf, busy;
  logic [25:0] q;
  logic [23:0] rem;

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  vec_t tbl[9];

  always #5 clk = ~clk;

  mant_div_24bit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .rem(rem), .sticky(sticky),
    .dz(dz), .ovf(ovf), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [23:0] ai, input logic [23:0] bi);
    vec_t        v;
    logic [63:0] num;
    v.a = ai; v.b = bi; v.dz = 1'b0; v.ovf = 1'b0; v.lat = 26;
    v.rem = 24'd0; v.sticky = 1'b0; v.q = 26'd0;
    if (bi == 24'd0) begin
      v.dz = 1'b1; v.q = Q_SAT; v.lat = 1;
    end else if ({1'b0, ai} >= {bi, 1'b0}) begin
      v.ovf = 1'b1; v.q = Q_SAT; v.lat = 1;
    end else begin
      num      = {15'd0, ai, 25'd0};
      v.q      = 26'(num / {40'd0, bi});
      v.rem    = 24'(num % {40'd0, bi});
      v.sticky = (v.rem != 24'd0);
    end
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_q"},         64'(q),         64'd0);
    check({tag, "_rem"},       64'(rem),       64'd0);
    check({tag, "_sticky"},    64'(sticky),    64'd0);
    check({tag, "_dz"},        64'(dz),        64'd0);
    check({tag, "_ovf"},       64'(ovf),       64'd0);
  endtask

  // Drive one operation, measure latency, compare result, optionally backpressure for 'hold' cycles.
  task automatic do_op(input vec_t v, input int hold);
    vec_t e;
    int   lat;
    bit   seen;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    a = v.a; b = v.b; in_valid = 1'b1;
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 24'($urandom); b = 24'($urandom);
    check("out_valid_early", 64'(out_valid), 64'd0);
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    e = exp_q.pop_front();
    if (!seen) begin
      check("timeout_out_valid", 64'd0, 64'd1);
      return;
    end
    check("latency", 64'(lat),      64'(e.lat));
    check("q",       64'(q),        64'(e.q));
    check("rem",     64'(rem),      64'(e.rem));
    check("sticky",  64'(sticky),   64'(e.sticky));
    check("dz",      64'(dz),       64'(e.dz));
    check("ovf",     64'(ovf),      64'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 24'($urandom); b = 24'($urandom);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready",  64'(in_ready),  64'd0);
      check("hold_busy",      64'(busy),      64'd1);
      check("hold_q",         64'(q),         64'(e.q));
      check("hold_rem",       64'(rem),       64'(e.rem));
      check("hold_flags",     64'({sticky, dz, ovf}), 64'({e.sticky, e.dz, e.ovf}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_in_ready",  64'(in_ready),  64'd1);
    check("drain_busy",      64'(busy),      64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{24'h800000, 24'h800000, 26'h2000000, 24'h000000, 1'b0, 1'b0, 1'b0, 26};
    tbl[1] = '{24'hC00000, 24'h800000, 26'h3000000, 24'h000000, 1'b0, 1'b0, 1'b0, 26};
    tbl[2] = '{24'h800000, 24'hC00000, 26'h1555555, 24'h400000, 1'b1, 1'b0, 1'b0, 26};
    tbl[3] = '{24'h123456, 24'h000000, 26'h3FFFFFF, 24'h000000, 1'b0, 1'b1, 1'b0, 1};
    tbl[4] = '{24'h800000, 24'h000001, 26'h3FFFFFF, 24'h000000, 1'b0, 1'b0, 1'b1, 1};
    tbl[5] = '{24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 24'h000000, 1'b0, 1'b0, 1'b0, 26};
    tbl[6] = '{24'h000002, 24'h000001, 26'h3FFFFFF, 24'h000000, 1'b0, 1'b0, 1'b1, 1};
    tbl[7] = '{24'h000000, 24'h000005, 26'h0000000, 24'h000000, 1'b0, 1'b0, 1'b0, 26};
    tbl[8] = '{24'h000001, 24'h000003, 26'h0AAAAAA, 24'h000002, 1'b1, 1'b0, 1'b0, 26};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) do_op(tbl[i], 0);

    // Backpressure: result must hold and new requests must be ignored.
    do_op(tbl[2], 5);
    repeat (3) begin
      @(negedge clk);
      check("no_ghost_op", 64'({out_valid, busy}), 64'd0);
    end

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    a = 24'h800000; b = 24'hC00000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("calc_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("mid_reset");
    do_op(tbl[1], 0);

    for (int i = 0; i < 1000; i++) begin
      logic [23:0] ra, rb;
      ra = 24'h800000 | 24'($urandom_range(0, 32'h7FFFFF));
      rb = 24'h800000 | 24'($urandom_range(0, 32'h7FFFFF));
      do_op(model(ra, rb), int'($urandom_range(0, 2)));
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
